// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, trap cause codes,
// field bit positions, operation and FSM encodings.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [4:0] CAUSE_M_TIMER = 5'd7;
    localparam logic [4:0] CAUSE_M_EXT   = 5'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } trap_state_e;

    function automatic logic [31:0] csrApplyOp(input csr_op_e op,
                                               input logic [31:0] oldValue,
                                               input logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return oldValue | wdata;
            CSR_RC:  return oldValue & ~wdata;
            default: return oldValue;
        endcase
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for one asynchronous, level-sensitive interrupt line.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer: CSR read/modify/write, counters,
// interrupt recognition, and PC redirect for trap entry and mret.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  csr_op,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic        is_mret,
    input  logic        instr_valid,
    input  logic [31:0] pc_in,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc_out
);

    trap_state_e r_state, w_stateNext;

    logic        r_mstatusMie, r_mstatusMpie;
    logic        r_mieMtie, r_mieMeie;
    logic [31:0] r_mtvec, r_mepc, r_mcause;
    logic [63:0] r_mcycle, r_minstret;

    logic        w_mtip, w_meip;
    logic        w_irqExt, w_irqTmr, w_irq, w_trap, w_mret, w_wrEn;
    logic [4:0]  w_causeCode;
    logic [31:0] w_mtvecBase, w_trapTarget, w_oldValue, w_newValue;
    logic        w_unusedBits;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncTimer (
        .clk(clk), .rst(rst), .i_async(timer_irq), .o_sync(w_mtip)
    );

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncExt (
        .clk(clk), .rst(rst), .i_async(ext_irq), .o_sync(w_meip)
    );

    // Recognition is blocked in REDIRECT so the instruction being flushed cannot trap.
    assign w_irqExt    = r_mstatusMie & r_mieMeie & w_meip;
    assign w_irqTmr    = r_mstatusMie & r_mieMtie & w_mtip;
    assign w_irq       = (r_state == ST_RUN) && (w_irqExt || w_irqTmr);
    assign w_trap      = w_irq && instr_valid;
    assign w_mret      = is_mret && instr_valid && !w_irq;
    assign w_causeCode = w_irqExt ? CAUSE_M_EXT : CAUSE_M_TIMER;

    assign w_mtvecBase  = {r_mtvec[31:2], 2'b00};
    assign w_trapTarget = r_mtvec[0] ? (w_mtvecBase + {25'b0, w_causeCode, 2'b00})
                                     : w_mtvecBase;

    assign epc_taken = !rst && (w_trap || w_mret);
    assign epc_out   = w_trap ? w_trapTarget : r_mepc;

    always_comb begin
        w_oldValue = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                w_oldValue[12:11]         = 2'b11;
                w_oldValue[MSTATUS_MPIE] = r_mstatusMpie;
                w_oldValue[MSTATUS_MIE]  = r_mstatusMie;
            end
            CSR_MIE: begin
                w_oldValue[MIE_MEIE] = r_mieMeie;
                w_oldValue[MIE_MTIE] = r_mieMtie;
            end
            CSR_MIP: begin
                w_oldValue[MIE_MEIE] = w_meip;
                w_oldValue[MIE_MTIE] = w_mtip;
            end
            CSR_MTVEC:     w_oldValue = r_mtvec;
            CSR_MEPC:      w_oldValue = r_mepc;
            CSR_MCAUSE:    w_oldValue = r_mcause;
            CSR_MCYCLE:    w_oldValue = r_mcycle[31:0];
            CSR_MCYCLEH:   w_oldValue = r_mcycle[63:32];
            CSR_MINSTRET:  w_oldValue = r_minstret[31:0];
            CSR_MINSTRETH: w_oldValue = r_minstret[63:32];
            default:       w_oldValue = '0;
        endcase
    end

    assign csr_rdata    = csr_rd ? w_oldValue : '0;
    assign w_newValue   = csrApplyOp(csr_op_e'(csr_op), w_oldValue, csr_wdata);
    assign w_wrEn       = csr_wr && instr_valid && (csr_op != CSR_NONE) && !w_trap;
    assign w_unusedBits = ^pc_in[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN:      if (w_trap || w_mret) w_stateNext = ST_REDIRECT;
            ST_REDIRECT: w_stateNext = ST_RUN;
            default:     w_stateNext = ST_RUN;
        endcase
    end

    // Trap entry is applied last so it overrides both a CSR write and an mret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatusMie  <= 1'b0;
            r_mstatusMpie <= 1'b0;
            r_mieMtie     <= 1'b0;
            r_mieMeie     <= 1'b0;
            r_mtvec       <= {RESET_MTVEC[31:2], 1'b0, RESET_MTVEC[0]};
            r_mepc        <= '0;
            r_mcause      <= '0;
        end else begin
            if (w_wrEn) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        r_mstatusMie  <= w_newValue[MSTATUS_MIE];
                        r_mstatusMpie <= w_newValue[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        r_mieMtie <= w_newValue[MIE_MTIE];
                        r_mieMeie <= w_newValue[MIE_MEIE];
                    end
                    CSR_MTVEC:  r_mtvec  <= {w_newValue[31:2], 1'b0, w_newValue[0]};
                    CSR_MEPC:   r_mepc   <= {w_newValue[31:2], 2'b00};
                    CSR_MCAUSE: r_mcause <= w_newValue;
                    default: ;
                endcase
            end
            if (w_mret) begin
                r_mstatusMie  <= r_mstatusMpie;
                r_mstatusMpie <= 1'b1;
            end
            if (w_trap) begin
                r_mepc        <= {pc_in[31:2], 2'b00};
                r_mcause      <= {1'b1, 26'b0, w_causeCode};
                r_mstatusMpie <= r_mstatusMie;
                r_mstatusMie  <= 1'b0;
            end
        end
    end

    // A write to either counter half replaces that cycle's increment for the whole counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wrEn && csr_addr == CSR_MCYCLE) begin
                r_mcycle[31:0] <= w_newValue;
            end else if (w_wrEn && csr_addr == CSR_MCYCLEH) begin
                r_mcycle[63:32] <= w_newValue;
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_wrEn && csr_addr == CSR_MINSTRET) begin
                r_minstret[31:0] <= w_newValue;
            end else if (w_wrEn && csr_addr == CSR_MINSTRETH) begin
                r_minstret[63:32] <= w_newValue;
            end else if (instr_valid && !w_trap) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and trap sequencer for the 3-stage RV32I core. It is the responder for the decoder's CSR read/write strobes and `is_mret` flag. It holds the M-mode control/status and counter registers, synchronizes and prioritizes the timer and external interrupt lines, and produces the PC redirect for trap entry and `mret`. It sits beside the register file in the execute/writeback stage; read data feeds writeback select 2'b11.

## Interface
- `RESET_MTVEC`, default 32'h0000_0000: reset value of mtvec.
- `SYNC_STAGES`, default 2: flop depth of the interrupt-line synchronizer (≥2).
- `clk` input 1: core clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `csr_addr` input 12: CSR address (instr[31:20]).
- `csr_wdata` input 32: rs1 value or zero-extended uimm, selected upstream.
- `csr_op` input 2: 01 = RW, 10 = RS, 11 = RC, 00 = no write (funct3[1:0]).
- `csr_rd` input 1: CSR read strobe.
- `csr_wr` input 1: CSR write strobe.
- `is_mret` input 1: current instruction is mret.
- `instr_valid` input 1: an instruction occupies the stage this cycle (not a bubble).
- `pc_in` input 32: PC of that instruction.
- `timer_irq` input 1: asynchronous timer interrupt level.
- `ext_irq` input 1: asynchronous external interrupt level.
- `csr_rdata` output 32: CSR read value, combinational.
- `epc_taken` output 1: redirect the PC this cycle.
- `epc_out` output 32: redirect target.

## Operation
- **Implemented CSRs:**
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11.
  - mie 0x304: MTIE[7] and MEIE[11] writable.
  - mtvec 0x305: bit 1 reads 0.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mip 0x344: read-only; MTIP[7] and MEIP[11] are the synchronized lines.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
- **Unimplemented addresses:** read 0; writes are ignored; no illegal-instruction trap.
- **Write value:** RW gives `wdata`; RS gives `old | wdata`; RC gives `old & ~wdata`. Written only when `csr_wr && instr_valid && csr_op != 0`.
- **Read data:** `csr_rdata` is the pre-write (old) value when `csr_rd`, else 0.
- **Interrupt pending:** `irq = MIE & ((MEIE & MEIP) | (MTIE & MTIP))`. External has priority over timer.
- **Trap entry** (`irq && instr_valid`):
  - The current instruction is abandoned: its CSR write, mret and minstret increment are suppressed.
  - mepc ← `pc_in`.
  - mcause ← 32'h8000_000B (external) or 32'h8000_0007 (timer).
  - MPIE ← MIE; MIE ← 0.
  - `epc_taken` = 1; `epc_out` = mtvec base if mtvec[0] = 0, else base + 4×cause code.
- **mret** (`is_mret && instr_valid && !irq`):
  - `epc_taken` = 1; `epc_out` = mepc.
  - MIE ← MPIE; MPIE ← 1.
- **Counters:**
  - mcycle increments every cycle.
  - minstret increments on each `instr_valid` that is not abandoned.
  - 64-bit wrap to 0.
  - A CSR write to any counter half overrides that cycle's increment for the whole counter: the written half takes `wdata`, the other half holds.
- **Trap FSM:**
  - RUN → REDIRECT on trap entry or mret.
  - REDIRECT → RUN unconditionally after one cycle.
  - In REDIRECT, interrupt recognition is blocked, so the instruction being flushed cannot trap.

## Timing
- `csr_rdata`, `epc_taken` and `epc_out` are combinational from the current inputs and state.
- Register updates take effect at the next rising edge; a back-to-back read returns the new value.
- Interrupt latency: `SYNC_STAGES` cycles from line assertion to MIP visible. Recognition happens at the first following cycle with `instr_valid` in RUN.
- Deassertion of a line before recognition cancels the interrupt. Lines are level-sensitive and not latched.
- Simultaneous trap entry and CSR write to mstatus: the trap update wins.
- Simultaneous trap entry and mret: trap wins, and mepc ← `pc_in` of the mret.
- Asynchronous reset, mid-redirect or otherwise:
  - FSM → RUN; `epc_taken` = 0 immediately.
  - mstatus MIE = MPIE = 0; mie, mepc, mcause and counters = 0; mtvec = `RESET_MTVEC`.
  - Synchronizer flops cleared.

## Structure
- `csr_pkg`: CSR address constants, mcause codes, `csr_op_e` enum, mstatus/mie bit-index constants, FSM state enum.
- Sub-module `irq_sync`: parameterized `SYNC_STAGES` flop chain, async active-high reset to 0, instantiated once per interrupt line.

## Test plan
- **Reset:** assert `rst` mid-REDIRECT → `epc_taken` = 0 at once; read mtvec = `RESET_MTVEC`; mstatus reads 32'h0000_1800.
- **CSR ops:**
  - RW mie ← 32'hFFFF_FFFF → reads 32'h0000_0880.
  - RS mstatus 0x8 → MIE = 1.
  - RC mstatus 0x8 → MIE = 0.
  - Read of 0x7C0 → 0.
- **Timer trap:**
  - Setup: mtvec = 32'h100, MIE = 1, MTIE = 1; raise `timer_irq`.
  - After 2 cycles, next valid instruction at `pc_in` = 32'h40 → `epc_taken`, `epc_out` = 32'h100.
  - Registers: mepc = 32'h40, mcause = 32'h8000_0007, MIE = 0, MPIE = 1.
  - The mret that follows → `epc_out` = 32'h40, MIE = 1.
- **Vectored priority:** mtvec = 32'h201, both lines high → `epc_out` = 32'h22C, mcause = 32'h8000_000B.
- **Collision:** interrupt pending on a cycle carrying a CSR write to mie → mie unchanged, trap taken. Interrupt pending in the cycle after redirect → not taken until the following cycle.
- **Counters:**
  - Write mcycle = 32'hFFFF_FFFF with mcycleh = 0 → two cycles later mcycleh = 1.
  - minstret does not count bubbles or abandoned instructions.
